// File: rtl/alu_exec_stage.sv
// Two-stage ALU execute pipeline: S1 captures the operation, S2 holds the
// computed result and flags. Carries a chaining accumulator and a handshake counter.
module alu_exec_stage #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic             acc_sel,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     result,
  output logic             carry,
  output logic             zero,
  output logic [N-1:0]     acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_INC = 3'd2,
    OP_DEC = 3'd3,
    OP_INV = 3'd4,
    OP_AND = 3'd5,
    OP_OR  = 3'd6,
    OP_XOR = 3'd7
  } op_e;

  logic         s1_valid;
  op_e          s1_op;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;
  logic         s1_acc_sel;

  logic         s2_load;
  logic         s1_load;
  logic         accept;

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // producer holds valid and its payload until then, ready never waits on valid.
  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = s1_valid && s2_load;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  logic [N-1:0] opa;
  logic [N:0]   sum;
  logic [N-1:0] calc_res;
  logic         calc_c;

  // Bit N of the widened add/subtract is the carry, or the borrow for SUB/DEC.
  always_comb begin
    opa      = s1_acc_sel ? acc : s1_a;
    sum      = '0;
    calc_res = '0;
    calc_c   = 1'b0;
    case (s1_op)
      OP_ADD: begin
        sum      = {1'b0, opa} + {1'b0, s1_b};
        calc_res = sum[N-1:0];
        calc_c   = sum[N];
      end
      OP_SUB: begin
        sum      = {1'b0, opa} - {1'b0, s1_b};
        calc_res = sum[N-1:0];
        calc_c   = sum[N];
      end
      OP_INC: begin
        sum      = {1'b0, opa} + (N+1)'(1);
        calc_res = sum[N-1:0];
        calc_c   = sum[N];
      end
      OP_DEC: begin
        sum      = {1'b0, opa} - (N+1)'(1);
        calc_res = sum[N-1:0];
        calc_c   = sum[N];
      end
      OP_INV: calc_res = ~opa;
      OP_AND: calc_res = opa & s1_b;
      OP_OR:  calc_res = opa | s1_b;
      OP_XOR: calc_res = opa ^ s1_b;
      default: calc_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_op      <= OP_ADD;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_acc_sel <= 1'b0;
      out_valid  <= 1'b0;
      result     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      acc        <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_op      <= op_e'(op);
        s1_a       <= a;
        s1_b       <= b;
        s1_acc_sel <= acc_sel;
      end else if (s1_load) begin
        s1_valid <= 1'b0;
      end

      if (s1_load) begin
        out_valid <= 1'b1;
        result    <= calc_res;
        carry     <= calc_c;
        zero      <= (calc_res == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      // Clear wins, but the transfer this cycle already consumed the old acc.
      if (acc_clr) begin
        acc <= '0;
      end else if (s1_load) begin
        acc <= calc_res;
      end

      if (out_valid && out_ready) begin
        op_count <= op_count + 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_exec_stage.md
ALU_EXEC_STAGE -- requirements
Module: alu_exec_stage

Interface
REQ-001 SHALL have parameter N, default 8, meaning operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of completed-operation counter.
REQ-003 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have in_valid  input  1  upstream has an operation.
REQ-006 SHALL have in_ready  output  1  stage can accept an operation.
REQ-007 SHALL have op  input  3  opcode: 0 ADD, 1 SUB, 2 INC, 3 DEC, 4 INV, 5 AND, 6 OR, 7 XOR.
REQ-008 SHALL have a  input  N  operand A.
REQ-009 SHALL have b  input  N  operand B, ignored by INC/DEC/INV.
REQ-010 SHALL have acc_sel  input  1  use accumulator in place of operand A.
REQ-011 SHALL have acc_clr  input  1  synchronous accumulator clear, not gated by handshake.
REQ-012 SHALL have out_valid  output  1  result registered and presented.
REQ-013 SHALL have out_ready  input  1  downstream accepts result.
REQ-014 SHALL have result  output  N  operation result.
REQ-015 SHALL have carry  output  1  carry/borrow flag of result.
REQ-016 SHALL have zero  output  1  result equals 0.
REQ-017 SHALL have acc  output  N  current accumulator value.
REQ-018 SHALL have op_count  output  CNT_W  number of completed output handshakes.

Function
REQ-019 SHALL be a two-stage pipeline: S1 registers op/a/b/acc_sel on accept; S2 registers computed result/flags.
REQ-020 SHALL accept an operation on a rising edge where in_valid && in_ready.
REQ-021 SHALL drive s2_load = !out_valid || out_ready; s1_load (transfer S1->S2) = s1_valid && s2_load.
REQ-022 SHALL drive in_ready = !s1_valid || s2_load, combinationally, sustaining one operation per cycle with no bubbles.
REQ-023 SHALL present result two cycles after accept when out_ready held high (latency 2).
REQ-024 SHALL compute at S1->S2 transfer with operand A = acc register value if S1 acc_sel else S1 a.
REQ-025 SHALL compute modulo 2^N: ADD A+B, SUB A-B, INC A+1, DEC A-1, INV ~A, AND A&B, OR A|B, XOR A^B.
REQ-026 SHALL set carry = bit N of the N+1-bit sum for ADD/INC, = 1 on borrow (A<B unsigned for SUB, A==0 for DEC), = 0 for INV/AND/OR/XOR.
REQ-027 SHALL set zero = (result == 0) for every opcode.
REQ-028 SHALL load acc with the computed result on every S1->S2 transfer, so back-to-back acc_sel operations chain without hazard.
REQ-029 SHALL clear acc to 0 on a cycle with acc_clr=1; acc_clr SHALL win over a simultaneous transfer update, while that transfer still uses the pre-clear acc value.
REQ-030 SHALL hold result, carry, zero stable while out_valid && !out_ready.
REQ-031 SHALL clear out_valid when out_ready=1 and no S1->S2 transfer occurs that cycle.
REQ-032 SHALL increment op_count by 1 on every out_valid && out_ready cycle, wrapping from 2^CNT_W-1 to 0.
REQ-033 SHALL never drop or duplicate an accepted operation under any in_valid/out_ready pattern.

Reset
REQ-034 SHALL on rst=1 immediately set s1_valid=0, out_valid=0, result=0, carry=0, zero=0, acc=0, op_count=0, independent of clk.
REQ-035 SHALL discard any in-flight operations on reset mid-operation; in_ready SHALL be 1 while rst=1.
REQ-036 SHALL resume accepting on the first rising edge after rst deasserts.

Verification
REQ-037 SHALL cover: N=8, out_ready=1, ADD a=8'hFF b=8'h01 -> 2 cycles later result=8'h00, carry=1, zero=1, op_count=1.
REQ-038 SHALL cover: SUB a=8'h03 b=8'h05 -> result=8'hFE, carry=1, zero=0; DEC a=8'h00 -> result=8'hFF, carry=1.
REQ-039 SHALL cover: acc=0, back-to-back INC acc_sel=1 x3 on consecutive cycles -> results 1,2,3, acc=3, no in_ready deassertion.
REQ-040 SHALL cover: out_ready=0 with 3 operations offered -> 2 accepted, in_ready=0, result held; out_ready=1 -> results drain in order, none lost.
REQ-041 SHALL cover: acc_clr=1 same cycle as ADD acc_sel=1 (acc=5, b=2) -> result=7, acc=0 after edge.
REQ-042 SHALL cover: rst asserted between edges with both stages full -> out_valid=0, acc=0, op_count=0 before next edge.
